// File: rtl/rv32i_dmem_bridge.sv
// RV32I data-memory bridge: turns pipeline load/store requests into Avalon-MM transactions.
// Optional one-entry posted write buffer enabled by defining RV32I_DMEM_WRBUF_EN.
module rv32i_dmem_bridge #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  st_be,
  input  logic        load,
  input  logic        store,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        bus_err,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid
);

  localparam int unsigned CNT_W = 8;
  // Counter saturates at 255, so larger limits behave as 255.
  localparam logic [CNT_W:0] TIMEOUT_LIM =
    (WAIT_TIMEOUT > 255) ? 9'd255 : (CNT_W+1)'(WAIT_TIMEOUT);
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_DONE, WR_REQ} state_e;

  state_e             state_q, state_d;
  logic               avm_read_q, avm_read_d;
  logic               avm_write_q, avm_write_d;
  logic [31:0]        avm_address_q, avm_address_d;
  logic [31:0]        avm_writedata_q, avm_writedata_d;
  logic [3:0]         avm_be_q, avm_be_d;
  logic [31:0]        ld_data_q, ld_data_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_pend_c;
  logic               wr_busy_c;

`ifdef RV32I_DMEM_WRBUF_EN
  // The avm write registers double as the one-entry buffer.
  assign wr_pend_c = avm_write_q;
  assign wr_busy_c = avm_write_q | (state_q != IDLE);
`else
  logic wr_done_q, wr_done_d;
  // wr_done_q marks the completion cycle, where the held store must not relaunch.
  assign wr_pend_c = 1'b0;
  assign wr_busy_c = !((state_q == IDLE) && wr_done_q);
`endif

  assign stall = reset_n & ((load & (state_q != RD_DONE)) |
                            (store & wr_busy_c) |
                            (load & wr_pend_c));

  assign ld_data        = ld_data_q;
  assign bus_err        = bus_err_q;
  assign avm_address    = avm_address_q;
  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_writedata  = avm_writedata_q;
  assign avm_byteenable = avm_be_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_writedata_q <= '0;
      avm_be_q        <= '0;
      ld_data_q       <= '0;
      bus_err_q       <= 1'b0;
      cnt_q           <= '0;
`ifndef RV32I_DMEM_WRBUF_EN
      wr_done_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_address_q   <= avm_address_d;
      avm_writedata_q <= avm_writedata_d;
      avm_be_q        <= avm_be_d;
      ld_data_q       <= ld_data_d;
      bus_err_q       <= bus_err_d;
      cnt_q           <= cnt_d;
`ifndef RV32I_DMEM_WRBUF_EN
      wr_done_q       <= wr_done_d;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    avm_read_d      = avm_read_q;
    avm_write_d     = avm_write_q;
    avm_address_d   = avm_address_q;
    avm_writedata_d = avm_writedata_q;
    avm_be_d        = avm_be_q;
    ld_data_d       = ld_data_q;
    bus_err_d       = 1'b0;
    cnt_d           = cnt_q;
`ifdef RV32I_DMEM_WRBUF_EN
    if (avm_write_q && !avm_waitrequest) avm_write_d = 1'b0;
`else
    wr_done_d       = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (load) begin
          if (!wr_pend_c) begin
            state_d       = RD_REQ;
            avm_read_d    = 1'b1;
            avm_address_d = addr;
            avm_be_d      = 4'b1111;
          end
        end else if (store) begin
`ifdef RV32I_DMEM_WRBUF_EN
          if (!avm_write_q) begin
`else
          if (!wr_done_q) begin
            state_d         = WR_REQ;
`endif
            avm_write_d     = 1'b1;
            avm_address_d   = addr;
            avm_writedata_d = wdata;
            avm_be_d        = st_be;
          end
        end
      end
      RD_REQ: begin
        if (!avm_waitrequest) begin
          avm_read_d = 1'b0;
          cnt_d      = '0;
          if (avm_readdatavalid) begin
            ld_data_d = avm_readdata;
            state_d   = RD_DONE;
          end else begin
            state_d   = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (avm_readdatavalid) begin
          ld_data_d = avm_readdata;
          state_d   = RD_DONE;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
          if (({1'b0, cnt_q} + 9'd1) >= TIMEOUT_LIM) begin
            ld_data_d = TIMEOUT_DATA;
            bus_err_d = 1'b1;
            state_d   = RD_DONE;
          end
        end
      end
      RD_DONE: state_d = IDLE;
`ifndef RV32I_DMEM_WRBUF_EN
      WR_REQ: begin
        if (!avm_waitrequest) begin
          avm_write_d = 1'b0;
          wr_done_d   = 1'b1;
          state_d     = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

endmodule
